ps2_move_decoder: RTL and testbench

PS2_MOVE_DECODER -- requirements
Module: ps2_move_decoder

---
 rtl/tetris_pkg.sv | 24 ++
 rtl/ps2_line_filter.sv | 39 +++
 rtl/ps2_move_decoder.sv | 159 +++++++++++++++
 tb/tb_ps2_move_decoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris PS/2 front end: scancodes and receive-FSM encoding.
package tetris_pkg;

  localparam logic [7:0] ScExt   = 8'hE0;
  localparam logic [7:0] ScBrk   = 8'hF0;
  localparam logic [7:0] ScLeft  = 8'h6B;
  localparam logic [7:0] ScRight = 8'h74;
  localparam logic [7:0] ScUp    = 8'h75;
  localparam logic [7:0] ScDown  = 8'h72;
  localparam logic [7:0] ScSpace = 8'h29;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // PS/2 uses odd parity across the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(logic [7:0] data, logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter that only accepts a new level after
// FilterLen consecutive identical samples. Both stages reset to the idle-high level.
module ps2_line_filter #(
  parameter int unsigned FilterLen = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic line_o
);

  localparam int unsigned CntW = (FilterLen > 1) ? $clog2(FilterLen) : 1;

  logic            sync1_q, sync2_q, filt_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FilterLen - 1)) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard receiver that turns arrow and space make codes into one-cycle Tetris
// move pulses; also exposes the raw received byte and framing errors.
module ps2_move_decoder
  import tetris_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       mv_left,
  output logic       mv_right,
  output logic       mv_rot,
  output logic       mv_soft,
  output logic       mv_hard,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_f, dat_f, clk_prev_q, fall;

  ps2_line_filter #(.FilterLen(FILTER_LEN)) u_clk_filter (
    .clk_i  (CLOCK_50),
    .rst_ni (resetn),
    .line_i (PS2_CLK),
    .line_o (clk_f)
  );

  ps2_line_filter #(.FilterLen(1)) u_dat_filter (
    .clk_i  (CLOCK_50),
    .rst_ni (resetn),
    .line_i (PS2_DAT),
    .line_o (dat_f)
  );

  assign fall = clk_prev_q & ~clk_f;

  rx_state_e      state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q, rx_byte_q;
  logic           parity_q, rx_valid_q, frame_err_q;
  logic [ToW-1:0] idle_cnt_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_prev_q  <= 1'b1;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      idle_cnt_q  <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_prev_q  <= clk_f;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (state_q == StIdle || fall) begin
        idle_cnt_q <= '0;
      end else begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end

      if (state_q != StIdle && !fall && idle_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
        state_q     <= StIdle;
        frame_err_q <= 1'b1;
      end else if (fall) begin
        unique case (state_q)
          StIdle: begin
            if (!dat_f) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          StData: begin
            shift_q   <= {dat_f, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            parity_q <= dat_f;
            state_q  <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            if (dat_f && odd_parity_ok(shift_q, parity_q)) begin
              rx_byte_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  logic ext_q, brk_q;
  logic mv_left_q, mv_right_q, mv_rot_q, mv_soft_q, mv_hard_q;

  // Prefix bytes only arm flags; the terminal code consumes and clears them.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      mv_left_q  <= 1'b0;
      mv_right_q <= 1'b0;
      mv_rot_q   <= 1'b0;
      mv_soft_q  <= 1'b0;
      mv_hard_q  <= 1'b0;
    end else begin
      mv_left_q  <= 1'b0;
      mv_right_q <= 1'b0;
      mv_rot_q   <= 1'b0;
      mv_soft_q  <= 1'b0;
      mv_hard_q  <= 1'b0;
      if (frame_err_q) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (rx_valid_q) begin
        if (rx_byte_q == ScExt) begin
          ext_q <= 1'b1;
        end else if (rx_byte_q == ScBrk) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (!brk_q) begin
            mv_left_q  <= ext_q && (rx_byte_q == ScLeft);
            mv_right_q <= ext_q && (rx_byte_q == ScRight);
            mv_rot_q   <= ext_q && (rx_byte_q == ScUp);
            mv_soft_q  <= ext_q && (rx_byte_q == ScDown);
            mv_hard_q  <= !ext_q && (rx_byte_q == ScSpace);
          end
        end
      end
    end
  end

  assign mv_left   = mv_left_q;
  assign mv_right  = mv_right_q;
  assign mv_rot    = mv_rot_q;
  assign mv_soft   = mv_soft_q;
  assign mv_hard   = mv_hard_q;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder: bit-banged PS/2 frames, pulse counting monitor.
module tb_ps2_move_decoder;

  localparam int unsigned Half = 40;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic       mv_left, mv_right, mv_rot, mv_soft, mv_hard;
  logic [7:0] rx_byte;
  logic       rx_valid, frame_err;

  ps2_move_decoder dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .mv_left   (mv_left),
    .mv_right  (mv_right),
    .mv_rot    (mv_rot),
    .mv_soft   (mv_soft),
    .mv_hard   (mv_hard),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int unsigned cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Monitor: sampled on the falling clock edge, away from the active edge.
  int unsigned n_valid = 0, n_err = 0, n_multi = 0;
  int unsigned n_mv[5] = '{0, 0, 0, 0, 0};
  int unsigned last_valid_cyc = 0, last_mv_cyc = 0;
  logic [7:0]  last_byte = 8'h00;
  logic [4:0]  mv_vec;
  assign mv_vec = {mv_hard, mv_soft, mv_rot, mv_right, mv_left};

  always @(negedge CLOCK_50) begin
    if (rx_valid) begin
      n_valid++;
      last_byte      = rx_byte;
      last_valid_cyc = cyc;
    end
    if (frame_err) n_err++;
    if (mv_vec != 5'd0) last_mv_cyc = cyc;
    for (int i = 0; i < 5; i++) if (mv_vec[i]) n_mv[i]++;
    if ($countones(mv_vec) > 1) n_multi++;
  end

  int unsigned n_checks = 0, n_pass = 0;
  int unsigned b_valid, b_err;
  int unsigned b_mv[5];
  int unsigned fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_err   = n_err;
    for (int i = 0; i < 5; i++) b_mv[i] = n_mv[i];
  endtask

  function automatic int unsigned mv_delta(input int idx);
    return n_mv[idx] - b_mv[idx];
  endfunction

  function automatic int unsigned mv_all();
    int unsigned s = 0;
    for (int i = 0; i < 5; i++) s += n_mv[i] - b_mv[i];
    return s;
  endfunction

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_bit(input logic b);
    @(posedge CLOCK_50);
    #1;
    PS2_DAT = b;
    wait_cycles(Half);
    PS2_CLK  = 1'b0;
    fall_cyc = cyc;
    wait_cycles(Half);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic good_parity);
    logic par;
    par = good_parity ? ~^d : ^d;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
    PS2_DAT = 1'b1;
    wait_cycles(100);
  endtask

  initial begin
    wait_cycles(3);
    check("reset_rx_byte", {24'd0, rx_byte}, 32'h00);
    check("reset_pulses", {25'd0, rx_valid, frame_err, mv_vec}, 32'h0);
    resetn = 1'b1;
    wait_cycles(20);

    // Space make: exact latency from the stop-bit clock fall
    snap();
    send_frame(8'h29, 1'b1);
    check("space_valid", n_valid - b_valid, 1);
    check("space_byte", {24'd0, last_byte}, 32'h29);
    check("space_valid_lat", last_valid_cyc - fall_cyc, 11);
    check("space_hard", mv_delta(4), 1);
    check("space_mv_lat", last_mv_cyc - fall_cyc, 12);
    check("space_no_err", n_err - b_err, 0);

    snap();
    send_frame(8'hE0, 1'b1);
    send_frame(8'h6B, 1'b1);
    check("left_pulse", mv_delta(0), 1);
    check("left_only", mv_all(), 1);
    check("left_valid", n_valid - b_valid, 2);

    // Break sequence, then a bare 6B after ext was consumed
    snap();
    send_frame(8'hE0, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h6B, 1'b1);
    send_frame(8'h6B, 1'b1);
    check("break_no_pulse", mv_all(), 0);
    check("break_valid", n_valid - b_valid, 4);

    snap();
    send_frame(8'h74, 1'b0);
    check("parity_err", n_err - b_err, 1);
    check("parity_no_valid", n_valid - b_valid, 0);
    check("parity_no_mv", mv_all(), 0);

    // Truncated frame abandoned by the idle timeout
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    PS2_DAT = 1'b1;
    wait_cycles(50200);
    check("timeout_err", n_err - b_err, 1);
    check("timeout_no_valid", n_valid - b_valid, 0);
    snap();
    send_frame(8'hE0, 1'b1);
    send_frame(8'h75, 1'b1);
    check("rot_pulse", mv_delta(2), 1);
    check("rot_only", mv_all(), 1);

    snap();
    for (int g = 0; g < 5; g++) begin
      PS2_CLK = 1'b0;
      wait_cycles(3);
      PS2_CLK = 1'b1;
      wait_cycles(50);
    end
    check("glitch_no_valid", n_valid - b_valid, 0);
    check("glitch_no_err", n_err - b_err, 0);
    check("glitch_no_mv", mv_all(), 0);

    snap();
    send_frame(8'hE0, 1'b1);
    send_frame(8'h72, 1'b1);
    send_frame(8'hE0, 1'b1);
    send_frame(8'h74, 1'b1);
    send_frame(8'h75, 1'b1);
    send_frame(8'h29, 1'b1);
    send_frame(8'h29, 1'b1);
    check("soft_pulse", mv_delta(3), 1);
    check("right_pulse", mv_delta(1), 1);
    check("bare_arrow_none", mv_delta(2), 0);
    check("typematic_hard", mv_delta(4), 2);

    // Reset dropped mid-frame
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    resetn  = 1'b0;
    PS2_DAT = 1'b1;
    PS2_CLK = 1'b1;
    wait_cycles(5);
    check("midrst_rx_byte", {24'd0, rx_byte}, 32'h00);
    check("midrst_pulses", {25'd0, rx_valid, frame_err, mv_vec}, 32'h0);
    snap();
    resetn = 1'b1;
    wait_cycles(2000);
    check("midrst_no_err", n_err - b_err, 0);
    check("midrst_no_valid", n_valid - b_valid, 0);
    send_frame(8'h29, 1'b1);
    check("post_rst_hard", mv_delta(4), 1);
    check("post_rst_byte", {24'd0, last_byte}, 32'h29);

    check("one_hot_mv", n_multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
